// File: rtl/scene_sequencer.sv
// Scene sequencer: runs N_SCENES scene submodules in wrap-around order,
// inserting one blanked HANDOFF cycle between scenes. It muxes the active
// scene's RAM-write and VGA buses onto the shared outputs and supports
// skip, abort-to-scene-0 and a per-scene timeout.
module scene_sequencer #(
  parameter int unsigned N_SCENES = 3,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned CBIT     = 11,
  parameter int unsigned AW       = 15,
  parameter int unsigned XW       = 8,
  parameter int unsigned YW       = 7,
  parameter int unsigned TW       = 28
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           enable,
  input  logic [N_SCENES-1:0]            f_scene,
  input  logic                           skip_req,
  input  logic                           abort_req,
  input  logic [TW-1:0]                  timeout_limit,
  input  logic [N_SCENES*(CBIT+1)-1:0]   dt_in,
  input  logic [N_SCENES*AW-1:0]         ad_in,
  input  logic [N_SCENES-1:0]            wr_in,
  input  logic [N_SCENES*XW-1:0]         vx_in,
  input  logic [N_SCENES*YW-1:0]         vy_in,
  input  logic [N_SCENES*(CBIT+1)-1:0]   vc_in,
  output logic [N_SCENES-1:0]            e_scene,
  output logic [CBIT:0]                  data,
  output logic [AW-1:0]                  addr,
  output logic                           wren,
  output logic [XW-1:0]                  VGA_X,
  output logic [YW-1:0]                  VGA_Y,
  output logic [CBIT:0]                  VGA_COLOR,
  output logic [SEL_W-1:0]               cur_scene,
  output logic                           scene_start
);

  localparam int unsigned DW = CBIT + 1;

  typedef enum logic [0:0] {StHandoff, StRun} state_e;

  state_e               r_state, w_state_d;
  logic [SEL_W-1:0]     r_cur_scene, w_cur_d;
  logic [N_SCENES-1:0]  r_e_scene, w_e_d;
  logic                 r_start, w_start_d;
  logic [TW-1:0]        r_cnt, w_cnt_d;

  logic                 w_fin;
  logic                 w_timeout;
  logic [SEL_W-1:0]     w_next_idx;

  // Finished level of the active scene only, timeout hit and wrap-around successor.
  always_comb begin
    w_fin = 1'b0;
    for (int k = 0; k < int'(N_SCENES); k++) begin
      if (r_cur_scene == SEL_W'(k)) w_fin = f_scene[k];
    end
    w_timeout  = (timeout_limit != '0) && (r_cnt == timeout_limit - TW'(1));
    w_next_idx = (r_cur_scene == SEL_W'(N_SCENES - 1)) ? '0 : r_cur_scene + SEL_W'(1);
  end

  // Next-state logic; everything holds while enable is low.
  always_comb begin
    w_state_d = r_state;
    w_cur_d   = r_cur_scene;
    w_e_d     = r_e_scene;
    w_start_d = r_start;
    w_cnt_d   = r_cnt;
    if (enable) begin
      unique case (r_state)
        StHandoff: begin
          w_state_d = StRun;
          w_cur_d   = abort_req ? '0 : r_cur_scene;
          for (int k = 0; k < int'(N_SCENES); k++) begin
            w_e_d[k] = (w_cur_d == SEL_W'(k));
          end
          w_start_d = 1'b1;
          w_cnt_d   = '0;
        end
        StRun: begin
          w_start_d = 1'b0;
          if (abort_req) begin
            w_state_d = StHandoff;
            w_cur_d   = '0;
            w_e_d     = '0;
          end else if (w_fin || skip_req || w_timeout) begin
            // Skip and finished together still advance by one scene.
            w_state_d = StHandoff;
            w_cur_d   = w_next_idx;
            w_e_d     = '0;
          end else begin
            w_cnt_d = (&r_cnt) ? r_cnt : r_cnt + TW'(1);
          end
        end
        default: w_state_d = StHandoff;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= StHandoff;
      r_cur_scene <= '0;
      r_e_scene   <= '0;
      r_start     <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_d;
      r_cur_scene <= w_cur_d;
      r_e_scene   <= w_e_d;
      r_start     <= w_start_d;
      r_cnt       <= w_cnt_d;
    end
  end

  // Shared-bus mux from the registered index; blanked outside RUN.
  always_comb begin
    data      = '0;
    addr      = '0;
    wren      = 1'b0;
    VGA_X     = '0;
    VGA_Y     = '0;
    VGA_COLOR = '0;
    if (r_state == StRun) begin
      for (int k = 0; k < int'(N_SCENES); k++) begin
        if (r_cur_scene == SEL_W'(k)) begin
          data      = dt_in[k*DW +: DW];
          addr      = ad_in[k*AW +: AW];
          wren      = wr_in[k];
          VGA_X     = vx_in[k*XW +: XW];
          VGA_Y     = vy_in[k*YW +: YW];
          VGA_COLOR = vc_in[k*DW +: DW];
        end
      end
    end
  end

  // Strobe is suppressed while the sequencer is frozen.
  always_comb begin
    e_scene     = r_e_scene;
    cur_scene   = r_cur_scene;
    scene_start = r_start & enable;
  end

endmodule

// File: tb/tb_scene_sequencer.sv
// Testbench for scene_sequencer: directed and randomized stimulus, expected
// outputs from a behavioural scene model pushed to a queue and checked by an
// independent monitor.
module tb_scene_sequencer;

  localparam int N     = 3;
  localparam int SEL_W = 2;
  localparam int CBIT  = 11;
  localparam int DW    = CBIT + 1;
  localparam int AW    = 15;
  localparam int XW    = 8;
  localparam int YW    = 7;
  localparam int TW    = 28;

  logic                 clock = 1'b0;
  logic                 resetn;
  logic                 enable;
  logic [N-1:0]         f_scene;
  logic                 skip_req;
  logic                 abort_req;
  logic [TW-1:0]        timeout_limit;
  logic [N*DW-1:0]      dt_in;
  logic [N*AW-1:0]      ad_in;
  logic [N-1:0]         wr_in;
  logic [N*XW-1:0]      vx_in;
  logic [N*YW-1:0]      vy_in;
  logic [N*DW-1:0]      vc_in;
  logic [N-1:0]         e_scene;
  logic [DW-1:0]        data;
  logic [AW-1:0]        addr;
  logic                 wren;
  logic [XW-1:0]        VGA_X;
  logic [YW-1:0]        VGA_Y;
  logic [DW-1:0]        VGA_COLOR;
  logic [SEL_W-1:0]     cur_scene;
  logic                 scene_start;

  scene_sequencer #(
    .N_SCENES(N), .SEL_W(SEL_W), .CBIT(CBIT), .AW(AW), .XW(XW), .YW(YW), .TW(TW)
  ) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .f_scene(f_scene),
    .skip_req(skip_req), .abort_req(abort_req), .timeout_limit(timeout_limit),
    .dt_in(dt_in), .ad_in(ad_in), .wr_in(wr_in), .vx_in(vx_in), .vy_in(vy_in),
    .vc_in(vc_in), .e_scene(e_scene), .data(data), .addr(addr), .wren(wren),
    .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOR(VGA_COLOR), .cur_scene(cur_scene),
    .scene_start(scene_start)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0]     e;
    logic [SEL_W-1:0] cur;
    logic             start;
    logic [DW-1:0]    data;
    logic [AW-1:0]    addr;
    logic             wren;
    logic [XW-1:0]    vx;
    logic [YW-1:0]    vy;
    logic [DW-1:0]    vc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: blanked flag, active scene number, enabled RUN cycles so far.
  bit     m_hand  = 1'b1;
  int     m_scene = 0;
  longint m_age   = 0;
  longint m_max   = (longint'(1) << TW) - 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t r;
    r.cur   = SEL_W'(m_scene);
    r.e     = m_hand ? '0 : N'(1) << m_scene;
    r.start = enable && !m_hand && (m_age == 0);
    if (m_hand) begin
      r.data = '0; r.addr = '0; r.wren = 1'b0; r.vx = '0; r.vy = '0; r.vc = '0;
    end else begin
      r.data = DW'(dt_in >> (m_scene * DW));
      r.addr = AW'(ad_in >> (m_scene * AW));
      r.wren = wr_in[m_scene];
      r.vx   = XW'(vx_in >> (m_scene * XW));
      r.vy   = YW'(vy_in >> (m_scene * YW));
      r.vc   = DW'(vc_in >> (m_scene * DW));
    end
    return r;
  endfunction

  task automatic model_reset();
    m_hand  = 1'b1;
    m_scene = 0;
    m_age   = 0;
  endtask

  // Effect of one rising edge on the model.
  task automatic model_edge();
    bit tmo;
    if (!resetn) begin
      model_reset();
    end else if (enable) begin
      if (m_hand) begin
        if (abort_req) m_scene = 0;
        m_hand = 1'b0;
        m_age  = 0;
      end else begin
        tmo = (timeout_limit != 0) && (m_age == longint'(timeout_limit) - 1);
        if (abort_req) begin
          m_scene = 0;
          m_hand  = 1'b1;
        end else if (f_scene[m_scene] || skip_req || tmo) begin
          m_scene = (m_scene + 1) % N;
          m_hand  = 1'b1;
        end else if (m_age < m_max) begin
          m_age = m_age + 1;
        end
      end
    end
  endtask

  // Called at a falling edge with inputs already applied; ends at the next falling edge.
  task automatic step();
    exp_q.push_back(model_out());
    model_edge();
    @(negedge clock);
  endtask

  task automatic rand_buses();
    dt_in = (N*DW)'({$urandom(), $urandom()});
    ad_in = (N*AW)'({$urandom(), $urandom()});
    wr_in = N'($urandom());
    vx_in = (N*XW)'($urandom());
    vy_in = (N*YW)'($urandom());
    vc_in = (N*DW)'({$urandom(), $urandom()});
  endtask

  task automatic quiet_run(input int n);
    for (int i = 0; i < n; i++) begin
      f_scene = '0; skip_req = 1'b0; abort_req = 1'b0;
      rand_buses();
      step();
    end
  endtask

  // Skip forward until the model sits in RUN of the requested scene.
  task automatic goto_scene(input int s);
    int guard = 0;
    while (!(!m_hand && m_scene == s) && guard < 20) begin
      f_scene = '0; abort_req = 1'b0;
      skip_req = !m_hand;
      rand_buses();
      step();
      guard++;
    end
    skip_req = 1'b0;
    chk("goto_scene_reached", 64'(guard < 20), 64'(1));
  endtask

  // Monitor: compares every presented output set against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("e_scene",     64'(e_scene),     64'(e.e));
        chk("cur_scene",   64'(cur_scene),   64'(e.cur));
        chk("scene_start", 64'(scene_start), 64'(e.start));
        chk("data",        64'(data),        64'(e.data));
        chk("addr",        64'(addr),        64'(e.addr));
        chk("wren",        64'(wren),        64'(e.wren));
        chk("VGA_X",       64'(VGA_X),       64'(e.vx));
        chk("VGA_Y",       64'(VGA_Y),       64'(e.vy));
        chk("VGA_COLOR",   64'(VGA_COLOR),   64'(e.vc));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SEL_W-1:0] held;
    resetn = 1'b0; enable = 1'b0; f_scene = '0; skip_req = 1'b0; abort_req = 1'b0;
    timeout_limit = '0;
    rand_buses();
    @(negedge clock);
    step();
    step();

    // Bring-up: one blank cycle, then scene 0 with the start strobe.
    resetn = 1'b1; enable = 1'b1;
    quiet_run(4);

    // Scene 0 finishes -> blank -> scene 1.
    f_scene = 3'b001; rand_buses(); step();
    quiet_run(4);

    // Scene 2 finishes -> wrap to scene 0; non-active finished bits ignored.
    goto_scene(2);
    f_scene = 3'b011; rand_buses(); step();
    f_scene = 3'b100; rand_buses(); step();
    quiet_run(4);

    // Timeout of 5 enabled RUN cycles.
    timeout_limit = TW'(5);
    quiet_run(16);

    // Timeout disabled: scene holds for 1000 cycles.
    timeout_limit = '0;
    quiet_run(3);
    held = cur_scene;
    quiet_run(1000);
    chk("held_1000", 64'(cur_scene), 64'(held));

    // Abort beats finished in scene 1.
    goto_scene(1);
    abort_req = 1'b1; f_scene = 3'b010; rand_buses(); step();
    abort_req = 1'b0; f_scene = '0;
    quiet_run(4);

    // Freeze mid-scene for 10 cycles with an armed timeout.
    timeout_limit = TW'(7);
    enable = 1'b0;
    f_scene = 3'b111; skip_req = 1'b1;
    for (int i = 0; i < 10; i++) step();
    enable = 1'b1; f_scene = '0; skip_req = 1'b0;
    quiet_run(10);

    // Asynchronous reset while scene 2 is writing.
    timeout_limit = '0;
    goto_scene(2);
    wr_in = '1;
    #1;
    chk("pre_reset_wren", 64'(wren), 64'(1));
    #1;
    resetn = 1'b0;
    #1;
    model_reset();
    chk("async_rst_e_scene",   64'(e_scene),   64'(0));
    chk("async_rst_wren",      64'(wren),      64'(0));
    chk("async_rst_cur_scene", 64'(cur_scene), 64'(0));
    @(negedge clock);
    step();
    resetn = 1'b1;
    quiet_run(3);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        timeout_limit = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(1, 10));
      end
      enable    = ($urandom_range(0, 7) != 0);
      f_scene   = '0;
      for (int k = 0; k < N; k++) f_scene[k] = ($urandom_range(0, 7) == 0);
      skip_req  = ($urandom_range(0, 15) == 0);
      abort_req = ($urandom_range(0, 31) == 0);
      rand_buses();
      step();
    end

    enable = 1'b1; f_scene = '0; skip_req = 1'b0; abort_req = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
